// File: rtl/parallel_to_serial.sv
// parallel_to_serial: captures an N-bit word on a rising rx_valid and hands it
// to a byte-wide UART MSB first. The first byte leaves immediately; each later
// byte waits for the transmitter's busy flag to fall.
module parallel_to_serial #(
  parameter int N         = 32,
  parameter int Ndiv4log2 = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_valid,
  input  logic [N-1:0]         rx_bytes,
  input  logic                 is_transmitting,
  output logic [7:0]           tx_byte,
  output logic                 tx_valid
);

  localparam int NUM_BYTES = N / 8;
  localparam logic [Ndiv4log2-1:0] LAST_IDX = Ndiv4log2'(NUM_BYTES - 1);
  localparam logic [Ndiv4log2-1:0] IDX_ONE  = Ndiv4log2'(1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t               state_q, state_d;
  logic                 rx_valid_q, busy_q;
  logic [N-1:0]         word_q, word_d;
  logic [Ndiv4log2-1:0] idx_q, idx_d;
  logic [7:0]           byte_d;
  logic                 vld_d;

  logic                 rise, fall;
  logic [N-1:0]         word_shl;
  logic [7:0]           cur_byte;

  assign rise = rx_valid & ~rx_valid_q;
  assign fall = busy_q & ~is_transmitting;

  // Byte at position idx counted from the MSB: shift it up into the top lane.
  assign word_shl = word_q << {idx_q, 3'b000};
  assign cur_byte = word_shl[N-1 -: 8];

  // State register plus all datapath/output registers; reset wins over events.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      word_q     <= '0;
      idx_q      <= '0;
      tx_byte    <= 8'h00;
      tx_valid   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_valid_q <= rx_valid;
      busy_q     <= is_transmitting;
      word_q     <= word_d;
      idx_q      <= idx_d;
      tx_byte    <= byte_d;
      tx_valid   <= vld_d;
    end
  end

  // Next state: leave IDLE on an accepted multi-byte word, return after the last byte.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (rise && NUM_BYTES > 1) state_d = S_WAIT;
      S_WAIT: if (fall && idx_q == LAST_IDX) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs/datapath: a rise in IDLE or a fall in WAIT emits exactly one byte.
  // Events in the other state are deliberately dropped.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    byte_d = tx_byte;
    vld_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          word_d = rx_bytes;
          byte_d = rx_bytes[N-1 -: 8];
          vld_d  = 1'b1;
          idx_d  = IDX_ONE;
        end
      end
      S_WAIT: begin
        if (fall) begin
          byte_d = cur_byte;
          vld_d  = 1'b1;
          idx_d  = idx_q + IDX_ONE;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Bench for parallel_to_serial: a queue-based model of pending bytes checked
// every cycle, plus literal expectations at the directed points.
module tb_parallel_to_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [31:0] rx_bytes;
  logic        is_transmitting;
  logic [7:0]  tx_byte;
  logic        tx_valid;

  int tests = 0;
  int fails = 0;

  parallel_to_serial #(.N(32), .Ndiv4log2(3)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_bytes(rx_bytes),
    .is_transmitting(is_transmitting), .tx_byte(tx_byte), .tx_valid(tx_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: a word is "in flight" while bytes remain queued. A rise with nothing
  // queued emits the MSB and queues the rest; a fall pops the next byte.
  logic [7:0] pend[$];
  logic       m_prev_rx, m_prev_busy;
  logic       exp_v;
  logic [7:0] exp_b;
  bit         model_live = 0;

  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
      m_prev_rx = 0; m_prev_busy = 0;
      exp_v = 0; exp_b = 8'h00;
    end else begin
      exp_v = 0;
      if (pend.size() == 0) begin
        if (rx_valid && !m_prev_rx) begin
          exp_b = rx_bytes[31:24];
          exp_v = 1;
          pend.push_back(rx_bytes[23:16]);
          pend.push_back(rx_bytes[15:8]);
          pend.push_back(rx_bytes[7:0]);
        end
      end else if (m_prev_busy && !is_transmitting) begin
        exp_b = pend.pop_front();
        exp_v = 1;
      end
      m_prev_rx = rx_valid;
      m_prev_busy = is_transmitting;
    end
    model_live = 1;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      check("model_tx_valid", {7'b0, tx_valid}, {7'b0, exp_v});
      check("model_tx_byte", tx_byte, exp_b);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [7:0] b);
    check({name, "_valid"}, {7'b0, tx_valid}, {7'b0, v});
    if (v) check({name, "_byte"}, tx_byte, b);
  endtask

  task automatic busy_pulse(input int len);
    is_transmitting = 1;
    for (int i = 0; i < len; i++) step();
    is_transmitting = 0;
    step();
  endtask

  initial begin
    rst = 1; rx_valid = 0; rx_bytes = '0; is_transmitting = 0;
    step(); step();
    expect_out("reset", 1'b0, 8'h00);
    check("reset_byte", tx_byte, 8'h00);
    rst = 0;

    // Load and first byte
    rx_valid = 1; rx_bytes = 32'hDDCCBBAA;
    step(); expect_out("first_DD", 1'b1, 8'hDD);
    step(); expect_out("strobe_one_cycle", 1'b0, 8'h00);
    check("hold_DD", tx_byte, 8'hDD);

    // Gating: idle busy flag produces nothing
    step(); expect_out("gate0", 1'b0, 8'h00);
    step(); expect_out("gate1", 1'b0, 8'h00);
    is_transmitting = 1;
    step(); expect_out("busy_high", 1'b0, 8'h00);
    is_transmitting = 0;
    step(); expect_out("fall_CC", 1'b1, 8'hCC);
    step(); expect_out("after_CC", 1'b0, 8'h00);

    busy_pulse(1); expect_out("fall_BB", 1'b1, 8'hBB);
    busy_pulse(2); expect_out("fall_AA", 1'b1, 8'hAA);
    step(); expect_out("after_AA", 1'b0, 8'h00);
    // rx_valid still high: no reload, and a stray fall in IDLE is ignored
    busy_pulse(1); expect_out("no_reload", 1'b0, 8'h00);
    step(); expect_out("no_reload2", 1'b0, 8'h00);

    // Rearm
    rx_valid = 0; step();
    rx_valid = 1; rx_bytes = 32'h11223344;
    step(); expect_out("rearm_11", 1'b1, 8'h11);
    rx_valid = 0; step();
    rx_valid = 1; rx_bytes = 32'hAABBCCDD;
    step(); expect_out("rise_in_wait", 1'b0, 8'h00);

    // Long busy: nothing until the cycle after it falls
    is_transmitting = 1;
    for (int i = 0; i < 5; i++) begin
      step(); expect_out("long_busy", 1'b0, 8'h00);
    end
    is_transmitting = 0;
    step(); expect_out("long_fall_22", 1'b1, 8'h22);

    // Mid-word reset abandons 33/44
    rx_valid = 0; rst = 1;
    step(); expect_out("midreset", 1'b0, 8'h00);
    check("midreset_byte", tx_byte, 8'h00);
    rst = 0;
    busy_pulse(1); expect_out("abandon1", 1'b0, 8'h00);
    busy_pulse(3); expect_out("abandon2", 1'b0, 8'h00);

    // rx_valid high across reset release counts as a rise
    rst = 1; rx_valid = 1; rx_bytes = 32'h55667788;
    step();
    rst = 0;
    step(); expect_out("rise_after_reset", 1'b1, 8'h55);

    // Simultaneous rise and fall in IDLE: rise wins
    busy_pulse(1); expect_out("b66", 1'b1, 8'h66);
    busy_pulse(1); expect_out("b77", 1'b1, 8'h77);
    busy_pulse(1); expect_out("b88", 1'b1, 8'h88);
    rx_valid = 0; is_transmitting = 1; step();
    rx_valid = 1; is_transmitting = 0; rx_bytes = 32'h9ABCDEF0;
    step(); expect_out("rise_and_fall", 1'b1, 8'h9A);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
